// File: rtl/vertex_transform.sv
// Applies a 4x4 Q8.8 model-view-projection matrix to four vertices (w = 1.0),
// one clip-space element per cycle. Optional build macro: VTX_TRANSFORM_ROUND_EN.
module vertex_transform #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         mat_we,
  input  logic [3:0]   mat_addr,
  input  logic [W-1:0] mat_data,
  input  logic         start,
  input  logic [W-1:0] v1_x,
  input  logic [W-1:0] v1_y,
  input  logic [W-1:0] v1_z,
  input  logic [W-1:0] v2_x,
  input  logic [W-1:0] v2_y,
  input  logic [W-1:0] v2_z,
  input  logic [W-1:0] v3_x,
  input  logic [W-1:0] v3_y,
  input  logic [W-1:0] v3_z,
  input  logic [W-1:0] v4_x,
  input  logic [W-1:0] v4_y,
  input  logic [W-1:0] v4_z,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d11,
  output logic [W-1:0] d12,
  output logic [W-1:0] d13,
  output logic [W-1:0] d14,
  output logic [W-1:0] d21,
  output logic [W-1:0] d22,
  output logic [W-1:0] d23,
  output logic [W-1:0] d24,
  output logic [W-1:0] d31,
  output logic [W-1:0] d32,
  output logic [W-1:0] d33,
  output logic [W-1:0] d34,
  output logic [W-1:0] d41,
  output logic [W-1:0] d42,
  output logic [W-1:0] d43,
  output logic [W-1:0] d44
);

  localparam int PW   = 2 * W;
  localparam int ACCW = 2 * W + 2;
  localparam logic signed [W-1:0]    one_fx = W'(1) << FRAC;
  localparam logic signed [ACCW-1:0] rnd_c  = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0] max_c  = ACCW'((2 ** (W - 1)) - 1);
  localparam logic signed [ACCW-1:0] min_c  = ~max_c;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_reg, state_next;
  logic [3:0]            k_reg;
  logic                  done_reg;
  logic signed [W-1:0]   mat_reg    [4][4];
  logic signed [W-1:0]   vtx_reg    [4][3];
  logic signed [W-1:0]   shadow_reg [16];
  logic [W-1:0]          d_reg      [16];
  logic signed [W-1:0]   vtx_in     [4][3];

  always_comb begin
    vtx_in[0][0] = v1_x; vtx_in[0][1] = v1_y; vtx_in[0][2] = v1_z;
    vtx_in[1][0] = v2_x; vtx_in[1][1] = v2_y; vtx_in[1][2] = v2_z;
    vtx_in[2][0] = v3_x; vtx_in[2][1] = v3_y; vtx_in[2][2] = v3_z;
    vtx_in[3][0] = v4_x; vtx_in[3][1] = v4_y; vtx_in[3][2] = v4_z;
  end

  // Element k: vertex k[3:2], matrix row (output component) k[1:0].
  logic [1:0] row_sel, vtx_sel;
  assign row_sel = k_reg[1:0];
  assign vtx_sel = k_reg[3:2];

  logic signed [PW-1:0] prod [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mul
      if (gi < 3) begin : g_coord
        assign prod[gi] = PW'(mat_reg[row_sel][gi]) * PW'(vtx_reg[vtx_sel][gi]);
      end else begin : g_w
        assign prod[gi] = PW'(mat_reg[row_sel][gi]) * PW'(one_fx);
      end
    end
  endgenerate

  logic signed [ACCW-1:0] acc, acc_adj, shifted;
  logic signed [W-1:0]    sat_res;

  always_comb begin
    acc = ACCW'(prod[0]) + ACCW'(prod[1]) + ACCW'(prod[2]) + ACCW'(prod[3]);
`ifdef VTX_TRANSFORM_ROUND_EN
    acc_adj = acc + rnd_c;
`else
    acc_adj = acc;
`endif
    shifted = acc_adj >>> FRAC;
    if (shifted > max_c) begin
      sat_res = max_c[W-1:0];
    end else if (shifted < min_c) begin
      sat_res = min_c[W-1:0];
    end else begin
      sat_res = shifted[W-1:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (k_reg == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      done_reg  <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mat_reg[r][c] <= (r == c) ? one_fx : '0;
        end
        for (int c = 0; c < 3; c++) begin
          vtx_reg[r][c] <= '0;
        end
      end
      for (int e = 0; e < 16; e++) begin
        shadow_reg[e] <= '0;
        d_reg[e]      <= '0;
      end
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == DONE);
      // Matrix is frozen from the start edge until the run returns to IDLE.
      if (mat_we && state_reg == IDLE) begin
        mat_reg[mat_addr[3:2]][mat_addr[1:0]] <= mat_data;
      end
      if (state_reg == IDLE && start) begin
        vtx_reg <= vtx_in;
        k_reg   <= '0;
      end
      if (state_reg == CALC) begin
        shadow_reg[k_reg] <= sat_res;
        k_reg             <= k_reg + 4'd1;
      end
      if (state_reg == DONE) begin
        for (int e = 0; e < 16; e++) begin
          d_reg[e] <= shadow_reg[e];
        end
      end
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

  assign d11 = d_reg[0];  assign d12 = d_reg[1];  assign d13 = d_reg[2];  assign d14 = d_reg[3];
  assign d21 = d_reg[4];  assign d22 = d_reg[5];  assign d23 = d_reg[6];  assign d24 = d_reg[7];
  assign d31 = d_reg[8];  assign d32 = d_reg[9];  assign d33 = d_reg[10]; assign d34 = d_reg[11];
  assign d41 = d_reg[12]; assign d42 = d_reg[13]; assign d43 = d_reg[14]; assign d44 = d_reg[15];

endmodule

// File: tb/tb_vertex_transform.sv
// Randomized bench for vertex_transform against a plain-arithmetic matrix model.
module tb_vertex_transform;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        mat_we = 1'b0;
  logic [3:0]  mat_addr = '0;
  logic [15:0] mat_data = '0;
  logic        start = 1'b0;
  logic [15:0] vin [4][3];
  logic        busy, done;
  logic [15:0] d [16];

  int n_cmp = 0;
  int n_bad = 0;
  int m_mdl [4][4];

  vertex_transform #(.W(16), .FRAC(8)) dut (
    .CLK(CLK), .rst(rst),
    .mat_we(mat_we), .mat_addr(mat_addr), .mat_data(mat_data), .start(start),
    .v1_x(vin[0][0]), .v1_y(vin[0][1]), .v1_z(vin[0][2]),
    .v2_x(vin[1][0]), .v2_y(vin[1][1]), .v2_z(vin[1][2]),
    .v3_x(vin[2][0]), .v3_y(vin[2][1]), .v3_z(vin[2][2]),
    .v4_x(vin[3][0]), .v4_y(vin[3][1]), .v4_z(vin[3][2]),
    .busy(busy), .done(done),
    .d11(d[0]),  .d12(d[1]),  .d13(d[2]),  .d14(d[3]),
    .d21(d[4]),  .d22(d[5]),  .d23(d[6]),  .d24(d[7]),
    .d31(d[8]),  .d32(d[9]),  .d33(d[10]), .d34(d[11]),
    .d41(d[12]), .d42(d[13]), .d43(d[14]), .d44(d[15])
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m_mdl[r][c] = (r == c) ? 256 : 0;
  endtask

  // Clip component j of a vertex: dot(M row j, (x, y, z, 1.0)) in Q8.8, saturated.
  function automatic logic [15:0] ref_elem(input int j, input int x, input int y, input int z);
    longint acc;
    acc = longint'(m_mdl[j][0]) * x + longint'(m_mdl[j][1]) * y
        + longint'(m_mdl[j][2]) * z + longint'(m_mdl[j][3]) * 256;
`ifdef VTX_TRANSFORM_ROUND_EN
    acc = acc + 128;
`endif
    acc = acc >>> 8;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  function automatic logic [15:0] rnd_fx();
    if ($urandom_range(1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 16'h0800)) - 16'h0400;
  endfunction

  task automatic write_mat(input logic [3:0] wa, input logic [15:0] wd);
    @(negedge CLK);
    mat_we = 1'b1; mat_addr = wa; mat_data = wd;
    m_mdl[wa[3:2]][wa[1:0]] = int'($signed(wd));
    @(posedge CLK); #1;
    mat_we = 1'b0;
  endtask

  task automatic run_xform(input string tag, input bit wr, input logic [3:0] wa,
                           input logic [15:0] wd, input bit disturb);
    int sv [4][3];
    logic [15:0] exp [16];
    int lat;
    bit busy_ok;
    bit extra_done;
    @(negedge CLK);
    start = 1'b1;
    if (wr) begin
      mat_we = 1'b1; mat_addr = wa; mat_data = wd;
      m_mdl[wa[3:2]][wa[1:0]] = int'($signed(wd));
    end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++)
        sv[i][c] = int'($signed(vin[i][c]));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp[i*4+j] = ref_elem(j, sv[i][0], sv[i][1], sv[i][2]);
    @(posedge CLK); #1;
    start = 1'b0; mat_we = 1'b0;
    busy_ok = (busy === 1'b1);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++)
        vin[i][c] = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (disturb && n == 4) begin
        start = 1'b1; mat_we = 1'b1; mat_addr = 4'd0; mat_data = 16'h0000;
      end
      if (disturb && n == 5) begin
        start = 1'b0; mat_we = 1'b0;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check_val({tag, ".latency"}, lat, 17);
    check_val({tag, ".busy_run"}, busy_ok, 1);
    check_val({tag, ".busy_end"}, busy, 0);
    for (int e = 0; e < 16; e++)
      check_val($sformatf("%s.d%0d%0d", tag, e/4 + 1, e%4 + 1), d[e], exp[e]);
    @(posedge CLK); #1;
    check_val({tag, ".done_pulse"}, done, 0);
    if (disturb) begin
      extra_done = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(posedge CLK); #1;
        if (done === 1'b1) extra_done = 1'b1;
      end
      check_val({tag, ".no_extra_done"}, extra_done, 0);
    end
    $display("run %s: lat=%0d d11=%h d12=%h d13=%h d14=%h d44=%h", tag, lat, d[0], d[1], d[2], d[3], d[15]);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".done"}, done, 0);
    for (int e = 0; e < 16; e++)
      check_val($sformatf("%s.d%0d%0d", tag, e/4 + 1, e%4 + 1), d[e], 0);
  endtask

  task automatic set_v1(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    vin[0][0] = x; vin[0][1] = y; vin[0][2] = z;
  endtask

  task automatic scenario_identity(input string tag);
    set_v1(16'h0100, 16'h0200, 16'hFF00);
    run_xform(tag, 0, 4'd0, 16'h0, 0);
    check_val({tag, ".k_d11"}, d[0], 16'h0100);
    check_val({tag, ".k_d12"}, d[1], 16'h0200);
    check_val({tag, ".k_d13"}, d[2], 16'hFF00);
    check_val({tag, ".k_d14"}, d[3], 16'h0100);
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++)
        vin[i][c] = rnd_fx();
    mdl_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("reset");
    @(negedge CLK);
    rst = 1'b1;

    scenario_identity("s1");

    write_mat(4'd3, 16'h0A00);
    set_v1(16'h0100, 16'h0200, 16'h0300);
    run_xform("s2", 0, 4'd0, 16'h0, 0);
    check_val("s2.k_d11", d[0], 16'h0B00);

    set_v1(16'h7FFF, 16'h0000, 16'h0000);
    run_xform("s3a", 1, 4'd0, 16'h7FFF, 0);
    check_val("s3a.k_d11", d[0], 16'h7FFF);
    set_v1(16'h7FFF, 16'h0000, 16'h0000);
    run_xform("s3b", 1, 4'd0, 16'h8000, 0);
    check_val("s3b.k_d11", d[0], 16'h8000);

    write_mat(4'd0, 16'h0100);
    write_mat(4'd3, 16'h0000);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++)
        vin[i][c] = rnd_fx();
    run_xform("s4a", 0, 4'd0, 16'h0, 1);
    set_v1(16'h0300, 16'h0000, 16'h0000);
    run_xform("s4b", 0, 4'd0, 16'h0, 0);
    check_val("s4b.k_d11", d[0], 16'h0300);

    write_mat(4'd5, 16'h1234);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    rst = 1'b0;
    #1;
    mdl_reset();
    check_reset_state("s5");
    saw_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_val("s5.no_done", saw_done, 0);
    @(negedge CLK);
    rst = 1'b1;
    scenario_identity("s5r");

    write_mat(4'd0, 16'h0080);
    set_v1(16'h0001, 16'h0000, 16'h0000);
    run_xform("s6", 0, 4'd0, 16'h0, 0);
`ifdef VTX_TRANSFORM_ROUND_EN
    check_val("s6.k_d11", d[0], 16'h0001);
`else
    check_val("s6.k_d11", d[0], 16'h0000);
`endif

    for (int t = 0; t < 20; t++) begin
      int nw;
      nw = $urandom_range(1, 16);
      for (int w = 0; w < nw; w++)
        write_mat(4'($urandom), rnd_fx());
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 3; c++)
          vin[i][c] = rnd_fx();
      run_xform($sformatf("rnd%0d", t), ($urandom_range(1) == 1), 4'($urandom), rnd_fx(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vertex_transform.md
Name: vertex_transform

Overview:
- Upstream neighbour of the normalization stage: applies a 4x4 model-view-projection matrix to four object-space vertices.
- Produces homogeneous clip coordinates d11..d44. Row i is vertex i (x, y, z, w), which is exactly the input format of the normalization stage.
- Matrix is loaded through a register-write port. A computation runs serially, one output element per cycle, using 4 parallel multipliers.
- Outputs update atomically, so the downstream stage always sees a coherent set.

Parameters:
- W, 16, data width of matrix entries, vertex coordinates and outputs (signed Q8.8).
- FRAC, 8, fractional bits; the product shift amount.

Ports:
- CLK  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset (rst=0 resets).
- mat_we  in  1  matrix write strobe.
- mat_addr  in  4  matrix entry index; row = addr[3:2], col = addr[1:0].
- mat_data  in  W  signed Q8.8 matrix entry.
- start  in  1  request a transform; sampled when busy=0.
- v1_x, v1_y, v1_z, v2_x, v2_y, v2_z, v3_x, v3_y, v3_z, v4_x, v4_y, v4_z  in  W each  object-space vertex coords, signed Q8.8; w is implicitly 1.0 (0x0100).
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse; d outputs are newly valid.
- d11..d44  out  W each (16 ports)  clip coords, registered; dij = vertex i, component j (1=x, 2=y, 3=z, 4=w).

Behaviour:
- Reset (rst=0, async):
  - state IDLE; busy=0, done=0.
  - all d outputs = 0; shadow registers = 0; element counter k = 0.
  - matrix M = identity: diagonal 0x0100, all other entries 0x0000.
- FSM states IDLE, CALC, DONE.
  - IDLE: start=1 at edge T → latch all 12 vertex inputs, k=0, go to CALC, busy=1 from T.
  - CALC: each cycle computes element k, with vertex i = k[3:2] and row r = k[1:0]:
    - acc = M[r][0]*vx + M[r][1]*vy + M[r][2]*vz + M[r][3]*0x0100.
    - Each product is a signed 32-bit value; the sum is a signed 34-bit value.
    - Result = acc >>> FRAC (arithmetic shift), then saturate to [0x8000, 0x7FFF], then write to shadow[k].
    - k increments; after k=15 go to DONE (16 cycles in CALC).
  - DONE (1 cycle): copy all 16 shadow registers to d outputs simultaneously; done=1; busy=0 at the end of the cycle; return to IDLE.
- Latency: start sampled at edge T → done=1 and new d values visible after edge T+17. The next start is accepted at edge T+18 at the earliest.
- d outputs hold their value until the next DONE. They never show partial results.
- mat_we:
  - Applied only when busy=0: M[mat_addr] = mat_data at the edge.
  - Ignored while busy=1; the matrix is locked during computation.
  - If mat_we and start occur in the same IDLE cycle, the write takes effect first. The computation uses the updated entry.
- start while busy=1 is ignored; it is not queued.
- Vertex inputs may change freely after the start edge; the latched copies are used.
- Reset mid-CALC: async abort. All state and outputs return to reset values, the matrix returns to identity, and no done pulse is issued.
- Saturation: results above 0x7FFF clamp to 0x7FFF; results below 0x8000 clamp to 0x8000.

Optional Feature:
- Macro VTX_TRANSFORM_ROUND_EN.
  - Defined: add 1<<(FRAC-1) (0x80) to acc before the arithmetic shift, giving round-half-up.
  - Undefined: plain arithmetic-shift truncation toward minus infinity.
- Saturation, latency and all other behaviour are identical in both builds.

Test Plan:
1. Reset, no matrix writes, start with v1=(0x0100, 0x0200, 0xFF00) → done after edge T+17; d11=0x0100, d12=0x0200, d13=0xFF00, d14=0x0100; busy high for cycles T..T+17.
2. Write M[0][3] (addr 3) = 0x0A00, start with v1=(0x0100, 0x0200, 0x0300) → d11=0x0B00, d12=0x0200, d13=0x0300, d14=0x0100.
3. Saturation:
   - M[0][0]=0x7FFF, v1_x=0x7FFF → d11=0x7FFF.
   - M[0][0]=0x8000, v1_x=0x7FFF → d11=0x8000.
4. While busy, pulse start and write mat_addr=0 with data 0x0000 → no extra done; result matches the pre-busy matrix; the next run shows M[0][0] unchanged.
5. Start, then drive rst=0 at T+5 → busy=0, done never pulses, all d=0; a subsequent identity run reproduces scenario 1.
6. M[0][0]=0x0080, v1_x=0x0001 → d11=0x0001 with VTX_TRANSFORM_ROUND_EN defined, 0x0000 without.
